// File: rtl/mac_seq_ctrl.sv
// Purpose: sequences one MAC through a LEN-pair signed dot product per command, returning the sum.
// Latency: last pair accepted in cycle T -> out_valid high in T+2; len==0 -> out_valid 2 cycles after start.
// Backpressure: in_ready only while running; the result is held stable in OUT until out_ready.
//
// Ports:
//   clk, rst_n                 clock (rising edge) and asynchronous active-low reset
//   start, len, busy           command strobe (sampled in IDLE only), pair count, state != IDLE
//   in_valid/in_ready          data_in/weight_in pair handshake
//   mac_data/mac_weight/mac_op MAC operands and op (00 NOP, 01 CLEAR, 10 ACC, 11 LOAD)
//   mac_result                 MAC accumulator, registered inside the MAC
//   out_valid/out_ready        out_data result handshake
module mac_seq_ctrl #(
    parameter int IN_BIT     = 8,
    parameter int WEIGHT_BIT = 8,
    parameter int OUT_BIT    = 20,
    parameter int OP_BIT     = 2,
    parameter int LEN_BIT    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_BIT-1:0]    len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_BIT-1:0]     data_in,
    input  logic [WEIGHT_BIT-1:0] weight_in,
    output logic [IN_BIT-1:0]     mac_data,
    output logic [WEIGHT_BIT-1:0] mac_weight,
    output logic [OP_BIT-1:0]     mac_op,
    input  logic [OUT_BIT-1:0]    mac_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_BIT-1:0]    out_data
);

    localparam logic [OP_BIT-1:0] OP_NOP   = OP_BIT'(0);
    localparam logic [OP_BIT-1:0] OP_CLEAR = OP_BIT'(1);
    localparam logic [OP_BIT-1:0] OP_ACC   = OP_BIT'(2);
    localparam logic [OP_BIT-1:0] OP_LOAD  = OP_BIT'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [LEN_BIT-1:0]   cnt, cnt_nxt;
    logic [LEN_BIT-1:0]   len_q, len_nxt;
    logic [OUT_BIT-1:0]   out_nxt;
    logic                 fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            len_q    <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            len_q    <= len_nxt;
            out_data <= out_nxt;
        end
    end

    assign fire       = (state == RUN) && in_valid;
    assign busy       = (state != IDLE);
    assign in_ready   = (state == RUN);
    assign out_valid  = (state == OUT);
    // Zero operands on bubbles so a MAC that ignores op still adds nothing.
    assign mac_data   = fire ? data_in   : '0;
    assign mac_weight = fire ? weight_in : '0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        out_nxt   = out_data;
        mac_op    = OP_NOP;
        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt = len;
                    cnt_nxt = '0;
                    if (len == '0) begin
                        // Empty vector: clear the MAC so WAIT captures a zero sum.
                        mac_op    = OP_CLEAR;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (fire) begin
                    // LOAD on the first pair overwrites any stale sum, saving a clear cycle.
                    mac_op = (cnt == '0) ? OP_LOAD : OP_ACC;
                    if (cnt == len_q - LEN_BIT'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = WAIT;
                    end else begin
                        cnt_nxt = cnt + LEN_BIT'(1);
                    end
                end
            end
            WAIT: begin
                // MAC register has absorbed the last op by now.
                out_nxt   = mac_result;
                state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
